// File: rtl/imem_refill_if.sv
// Bundle between the instruction-cache line-fill port and the shared memory port.
// The refill unit takes the slave view; the cache and memory side take the master view.
interface imem_refill_if #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_W    = 64
);
    logic                 c_rd;
    logic [ADDR_W-1:0]    c_addr;
    logic [LINE_BITS-1:0] c_data;
    logic                 c_dv;
    logic                 c_err;
    logic                 m_req;
    logic [ADDR_W-1:0]    m_addr;
    logic                 m_gnt;
    logic [BEAT_BITS-1:0] m_rdata;
    logic                 m_rvalid;
    logic                 m_err;

    modport master (
        output c_rd, c_addr, m_gnt, m_rdata, m_rvalid, m_err,
        input  c_data, c_dv, c_err, m_req, m_addr
    );

    modport slave (
        input  c_rd, c_addr, m_gnt, m_rdata, m_rvalid, m_err,
        output c_data, c_dv, c_err, m_req, m_addr
    );
endinterface

// File: rtl/imem_refill.sv
// Instruction-cache line refill: fetches a line as ascending beats over a pipelined
// memory bus and presents it with a one-cycle c_dv (or c_err on a bus error).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for c_rd; latches the line base on accept
// S_FILL  | issuing beat requests and collecting responses
// S_DRAIN | fill abandoned (stale or error); swallowing outstanding beats
// S_DONE  | one cycle; pulses c_err, c_dv, or nothing for a stale fill
module imem_refill #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_W    = 64,
    parameter int MAX_OUT   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_refill_if.slave bus
);
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int OFFS  = $clog2(LINE_BITS / 8);
    localparam int BSH   = $clog2(BEAT_BITS / 8);
    localparam int CW    = $clog2(BEATS + 1);
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = ADDR_W - OFFS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        issued_q, issued_d;
    logic [CW-1:0]        received_q, received_d;
    logic [TW-1:0]        line_q, line_d;
    logic [LINE_BITS-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic                 stale_q, stale_d;

    logic [CW-1:0]        out_now;
    logic [CW-1:0]        out_nxt;
    logic                 issue;
    logic                 rx;
    logic                 stale_now;
    logic [IW-1:0]        rx_idx;
    logic                 unused_addr_lo;

    assign unused_addr_lo = ^bus.c_addr[OFFS-1:0];
    assign out_now        = issued_q - received_q;
    assign rx_idx         = received_q[IW-1:0];

    // Issue is gated by registered flags only, so a stale/error event stops
    // requests from the following cycle and no input reaches m_req combinationally.
    assign bus.m_req  = (state_q == S_FILL) && !err_q && !stale_q &&
                        (issued_q < CW'(BEATS)) && (out_now < CW'(MAX_OUT));
    assign bus.m_addr = {line_q, {OFFS{1'b0}}} + (ADDR_W'(issued_q) << BSH);
    assign bus.c_data = data_q;
    assign bus.c_dv   = (state_q == S_DONE) && !err_q && !stale_q;
    assign bus.c_err  = (state_q == S_DONE) && err_q;

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        received_d = received_q;
        line_d     = line_q;
        data_d     = data_q;
        err_d      = err_q;
        stale_d    = stale_q;
        issue      = bus.m_req && bus.m_gnt;
        rx         = bus.m_rvalid && (out_now != '0);
        stale_now  = !bus.c_rd || (bus.c_addr[ADDR_W-1:OFFS] != line_q);
        out_nxt    = out_now;

        unique case (state_q)
            S_IDLE: begin
                if (bus.c_rd) begin
                    line_d     = bus.c_addr[ADDR_W-1:OFFS];
                    issued_d   = '0;
                    received_d = '0;
                    err_d      = 1'b0;
                    stale_d    = 1'b0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (issue) begin
                    issued_d = issued_q + 1'b1;
                end
                if (rx) begin
                    data_d[rx_idx*BEAT_BITS +: BEAT_BITS] = bus.m_rdata;
                    received_d = received_q + 1'b1;
                    if (bus.m_err) begin
                        err_d = 1'b1;
                    end
                end
                if (stale_now) begin
                    stale_d = 1'b1;
                end
                out_nxt = issued_d - received_d;
                if (received_d == CW'(BEATS)) begin
                    state_d = S_DONE;
                end else if (err_d || stale_d) begin
                    state_d = (out_nxt == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rx) begin
                    received_d = received_q + 1'b1;
                end
                out_nxt = issued_q - received_d;
                if (out_nxt == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            issued_q   <= '0;
            received_q <= '0;
            line_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            line_q     <= line_d;
            data_q     <= data_d;
            err_q      <= err_d;
            stale_q    <= stale_d;
        end
    end
endmodule
